spi_mem_responder: RTL
======================

SPI_MEM_RESPONDER -- requirements
Module: spi_mem_responder

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset. All logic is clocked on the rising edge of clk and reset only by rst.
REQ-002 Parameters (name, default, meaning):
  - MEM_DEPTH, 32, number of bytes in the register array.
  - SYNC_STAGES, 2, synchronizer depth for the SPI inputs.
REQ-003 Ports (name, direction, width, meaning):
  - clk, in, 1, system clock.
  - rst, in, 1, synchronous active-high reset.
  - sclk, in, 1, SPI serial clock from the master, asynchronous to clk.
  - cs_n, in, 1, active-low chip select.
  - mosi, in, 1, master-to-responder serial data.
  - miso, out, 1, responder-to-master serial data.
  - done, out, 1, one-cycle pulse when a frame completes.
  - err, out, 1, one-cycle pulse coincident with done when the address is out of range.
  - busy, out, 1, high while a frame is in progress.

Function
REQ-004 SHALL pass sclk, cs_n and mosi through SYNC_STAGES flops. Edge detection uses the synchronized values only.
REQ-005 SPI mode 0:
  - mosi is sampled on the synchronized sclk rising edge.
  - miso is updated on the synchronized sclk falling edge.
  - sclk high and low phases are each at least 4 clk periods.
REQ-006 Frame is LSB-first.
  - Bit 0 is the wr flag.
  - Bits 1-8 are addr[7:0].
  - Write frames carry 8 more bits, data[7:0], for 17 mosi bits total.
REQ-007 State machine states: IDLE, CMD, ADDR, WDATA, RDATA, DRAIN.
REQ-008 IDLE goes to CMD on the synchronized cs_n falling edge, clearing the bit counter.
REQ-009 CMD captures wr on the first sclk rise, then goes to ADDR.
REQ-010 ADDR captures 8 bits. On the 8th rise it goes to WDATA if wr=1 and to RDATA if wr=0.
REQ-011 WDATA captures 8 bits. On the 8th rise:
  - If addr < MEM_DEPTH, it writes mem[addr] <= data.
  - It pulses done (and err when addr >= MEM_DEPTH).
  - It goes to DRAIN.
REQ-012 RDATA setup: on entry it loads a shift register with mem[addr], or 8'h00 if addr >= MEM_DEPTH.
REQ-013 RDATA shifting:
  - miso drives bit 0 on the first falling edge after entry and shifts LSB-first on each later fall.
  - On the 8th rise after entry it pulses done (and err if out of range), then goes to DRAIN.
REQ-014 DRAIN ignores further sclk edges and returns to IDLE on the cs_n rising edge.
REQ-015 A cs_n rising edge in CMD, ADDR, WDATA or RDATA SHALL abort the frame:
  - no memory write;
  - no done and no err;
  - return to IDLE on the next clk.
REQ-016 Simultaneous sclk and cs_n edges in the same clk: the cs_n edge wins.
REQ-017 miso is 0 whenever the responder is not in RDATA.
REQ-018 busy is high in every state except IDLE.
REQ-019 Latency: done asserts 1 + SYNC_STAGES clk cycles after the final raw sclk rising edge of the frame.
REQ-020 Memory contents persist across frames and across aborts.

Reset
REQ-021 While rst=1 at a clk edge:
  - state becomes IDLE;
  - counters are cleared;
  - miso=0, done=0, err=0, busy=0;
  - all synchronizer flops are set to idle bus levels (sclk=0, cs_n=1, mosi=0).
REQ-022 rst SHALL clear every memory byte to 8'h00.
REQ-023 rst asserted mid-frame abandons the frame with no write. After rst deasserts, a new frame starts only after a fresh cs_n falling edge.

Structure
REQ-024 spi_pkg SHALL hold the state enum, the default MEM_DEPTH, and the frame lengths (CMD_BITS=1, ADDR_BITS=8, DATA_BITS=8).
REQ-025 A sub-module spi_sync_edge SHALL provide per-signal synchronization and rise/fall pulses. It is instantiated for sclk and cs_n; mosi uses the synchronizer only.

Verification
REQ-026 Write then read:
  - Write frame wr=1, addr=8'h05, data=8'hA5 -> mem[5]=8'hA5; done pulses once; err=0.
  - Read frame addr=8'h05 -> miso bits 1,0,1,0,0,1,0,1 (LSB-first); done=1; err=0.
REQ-027 Out-of-range write: wr=1, addr=8'h20, data=8'hFF -> done and err pulse together; no memory byte changes.
REQ-028 Out-of-range read: wr=0, addr=8'h40 -> miso all 0; done and err pulse.
REQ-029 Abort: write to addr=8'h03 with data=8'h3C, cs_n raised after 12 bits -> no done; a subsequent read of addr 3 returns 8'h00.
REQ-030 Reset mid-read: rst pulsed during the 4th data bit of a read -> miso=0 and busy=0 next cycle; a following read of a previously written byte returns 8'h00.
REQ-031 Back-to-back frames: two writes (addr 0 data 8'h11, addr 31 data 8'h22) with cs_n high for 4 clk between them -> both bytes stored; two done pulses.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and frame constants for the SPI memory responder
//
// Purpose: holds the responder state enum, the default memory depth and the
// bit lengths of each frame field. No ports.
package spi_pkg;

  localparam int DEFAULT_MEM_DEPTH = 32;

  localparam int CMD_BITS  = 1;
  localparam int ADDR_BITS = 8;
  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RDATA,
    DRAIN
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall pulse outputs
//
// Purpose: brings one asynchronous input into the clk domain and reports
// single-cycle rise/fall pulses of the synchronized value.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset (chain forced to IDLE_VAL)
//   d     in  asynchronous input
//   rise  out one-cycle pulse on a synchronized 0->1 transition
//   fall  out one-cycle pulse on a synchronized 1->0 transition
module spi_sync_edge #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  // Edges are suppressed until the chain and the history flop hold real
  // samples, so a bus level that differs from the reset value does not look
  // like a fresh edge right after reset.
  logic [STAGES:0]   vld_q, vld_d;
  logic              q;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d   = sync_q[STAGES-1];
    vld_d    = '0;
    vld_d[0] = 1'b1;
    for (int i = 1; i <= STAGES; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{IDLE_VAL}};
      prev_q <= IDLE_VAL;
      vld_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      vld_q  <= vld_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = vld_q[STAGES] &  q & ~prev_q;
  assign fall = vld_q[STAGES] & ~q &  prev_q;

endmodule

// File: rtl/spi_mem_responder.sv
// rtl/spi_mem_responder.sv - SPI mode-0 responder backed by a small byte register array
//
// Purpose: decodes LSB-first frames {wr, addr[7:0], data[7:0]} from an SPI
// master, writes or reads a byte array and reports completion.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset (also clears the array)
//   sclk  in  SPI serial clock, asynchronous to clk
//   cs_n  in  active-low chip select
//   mosi  in  master-to-responder data
//   miso  out responder-to-master data, 0 outside a read data phase
//   done  out one-cycle pulse when a frame completes
//   err   out one-cycle pulse with done when the address is out of range
//   busy  out high while a frame is in progress
module spi_mem_responder
  import spi_pkg::*;
#(
  parameter int MEM_DEPTH   = DEFAULT_MEM_DEPTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic miso,
  output logic done,
  output logic err,
  output logic busy
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CW = $clog2((ADDR_BITS > DATA_BITS) ? ADDR_BITS : DATA_BITS);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sclk_sync (
    .clk (clk),
    .rst (rst),
    .d   (sclk),
    .rise(sclk_rise),
    .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_cs_sync (
    .clk (clk),
    .rst (rst),
    .d   (cs_n),
    .rise(cs_rise),
    .fall(cs_fall)
  );

  always_comb begin
    mosi_sync_d    = mosi_sync_q;
    mosi_sync_d[0] = mosi;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      mosi_sync_d[i] = mosi_sync_q[i-1];
    end
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 wr_q, wr_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [DATA_BITS-1:0] rd_shift_q, rd_shift_d;
  logic                 miso_q, miso_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [DATA_BITS-1:0] mem_q [MEM_DEPTH];
  logic                 mem_we;
  logic [AW-1:0]        mem_waddr;
  logic [DATA_BITS-1:0] mem_wdata;

  // Fields arrive LSB-first, so each new bit enters at the MSB and after a
  // full field the first bit has reached bit 0.
  logic [ADDR_BITS-1:0] addr_shift;
  logic [DATA_BITS-1:0] data_shift;
  assign addr_shift = {mosi_s, addr_q[ADDR_BITS-1:1]};
  assign data_shift = {mosi_s, data_q[DATA_BITS-1:1]};

  function automatic logic in_range(input logic [ADDR_BITS-1:0] a);
    return 32'(a) < MEM_DEPTH;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rd_shift_d = rd_shift_q;
    miso_d     = miso_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = addr_q[AW-1:0];
    mem_wdata  = data_shift;

    // Chip-select release outranks any sclk edge in the same cycle: it either
    // ends a drained frame or aborts a partial one without side effects.
    if (state_q != IDLE && cs_rise) begin
      state_d = IDLE;
      miso_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d = CMD;
            cnt_d   = '0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            wr_d    = mosi_s;
            cnt_d   = '0;
            state_d = ADDR;
          end
        end
        ADDR: begin
          if (sclk_rise) begin
            addr_d = addr_shift;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(ADDR_BITS - 1)) begin
              cnt_d = '0;
              if (wr_q) begin
                state_d = WDATA;
              end else begin
                state_d    = RDATA;
                rd_shift_d = in_range(addr_shift) ? mem_q[addr_shift[AW-1:0]] : '0;
                miso_d     = 1'b0;
              end
            end
          end
        end
        WDATA: begin
          if (sclk_rise) begin
            data_d = data_shift;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(DATA_BITS - 1)) begin
              cnt_d   = '0;
              mem_we  = in_range(addr_q);
              done_d  = 1'b1;
              err_d   = ~in_range(addr_q);
              state_d = DRAIN;
            end
          end
        end
        RDATA: begin
          if (sclk_rise) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(DATA_BITS - 1)) begin
              cnt_d   = '0;
              done_d  = 1'b1;
              err_d   = ~in_range(addr_q);
              miso_d  = 1'b0;
              state_d = DRAIN;
            end
          end else if (sclk_fall) begin
            miso_d     = rd_shift_q[0];
            rd_shift_d = {1'b0, rd_shift_q[DATA_BITS-1:1]};
          end
        end
        DRAIN: begin
        end
        default: begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_sync_q <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rd_shift_q  <= '0;
      miso_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rd_shift_q  <= rd_shift_d;
      miso_q      <= miso_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign miso = miso_q;
  assign done = done_q;
  assign err  = err_q;
  assign busy = (state_q != IDLE);

endmodule
